// File: rtl/alu_result_accumulator.sv
// ALU result statistics stage: collects a burst of N_SAMPLES results and
// presents saturating sum, min, max, count and overflow as one held beat.
module alu_result_accumulator #(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 24,
    parameter int N_SAMPLES = 1000,
    parameter int CNT_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_sum,
    output logic [DATA_W-1:0] res_max,
    output logic [DATA_W-1:0] res_min,
    output logic [CNT_W-1:0]  res_count,
    output logic              res_ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic             accept;
    logic             last;
    logic             open;
    logic [ACC_W:0]   sum_ext;

    assign open    = (state == IDLE) && start;
    assign accept  = (state == ACCUM) && in_valid;
    assign last    = accept && (res_count == CNT_W'(N_SAMPLES - 1));
    assign sum_ext = {1'b0, res_sum}
                   + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: start only opens a burst from IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = ACCUM;
            ACCUM:   if (last)      state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded purely from the state register
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        res_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                res_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Statistics: cleared on burst open, updated on each accepted sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_sum   <= '0;
            res_max   <= '0;
            res_min   <= '0;
            res_count <= '0;
            res_ovf   <= 1'b0;
        end else if (open) begin
            res_sum   <= '0;
            res_max   <= '0;
            res_min   <= '1;
            res_count <= '0;
            res_ovf   <= 1'b0;
        end else if (accept) begin
            if (sum_ext[ACC_W]) begin
                res_sum <= '1;
                res_ovf <= 1'b1;
            end else begin
                res_sum <= sum_ext[ACC_W-1:0];
            end
            if (in_data > res_max) res_max <= in_data;
            if (in_data < res_min) res_min <= in_data;
            res_count <= res_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_result_accumulator.sv
// Directed bench for alu_result_accumulator: small-burst, saturating
// and default-size instances driven from one linear sequence.
module tb_alu_result_accumulator;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance a: N_SAMPLES=4, default accumulator width
    logic        a_start, a_in_valid, a_in_ready, a_busy;
    logic        a_res_valid, a_res_ready, a_res_ovf;
    logic [15:0] a_in_data, a_res_max, a_res_min;
    logic [23:0] a_res_sum;
    logic [2:0]  a_res_count;

    // Instance s: N_SAMPLES=4, ACC_W=17 to exercise saturation
    logic        s_start, s_in_valid, s_in_ready, s_busy;
    logic        s_res_valid, s_res_ready, s_res_ovf;
    logic [15:0] s_in_data, s_res_max, s_res_min;
    logic [16:0] s_res_sum;
    logic [2:0]  s_res_count;

    // Instance d: default parameters
    logic        d_start, d_in_valid, d_in_ready, d_busy;
    logic        d_res_valid, d_res_ready, d_res_ovf;
    logic [15:0] d_in_data, d_res_max, d_res_min;
    logic [23:0] d_res_sum;
    logic [9:0]  d_res_count;

    alu_result_accumulator #(
        .DATA_W(16), .ACC_W(24), .N_SAMPLES(4), .CNT_W(3)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start),
        .in_valid(a_in_valid), .in_data(a_in_data),
        .in_ready(a_in_ready), .busy(a_busy),
        .res_valid(a_res_valid), .res_ready(a_res_ready),
        .res_sum(a_res_sum), .res_max(a_res_max), .res_min(a_res_min),
        .res_count(a_res_count), .res_ovf(a_res_ovf)
    );

    alu_result_accumulator #(
        .DATA_W(16), .ACC_W(17), .N_SAMPLES(4), .CNT_W(3)
    ) u_s (
        .clk(clk), .rst_n(rst_n), .start(s_start),
        .in_valid(s_in_valid), .in_data(s_in_data),
        .in_ready(s_in_ready), .busy(s_busy),
        .res_valid(s_res_valid), .res_ready(s_res_ready),
        .res_sum(s_res_sum), .res_max(s_res_max), .res_min(s_res_min),
        .res_count(s_res_count), .res_ovf(s_res_ovf)
    );

    alu_result_accumulator u_d (
        .clk(clk), .rst_n(rst_n), .start(d_start),
        .in_valid(d_in_valid), .in_data(d_in_data),
        .in_ready(d_in_ready), .busy(d_busy),
        .res_valid(d_res_valid), .res_ready(d_res_ready),
        .res_sum(d_res_sum), .res_max(d_res_max), .res_min(d_res_min),
        .res_count(d_res_count), .res_ovf(d_res_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int unsigned m_sum, m_min, m_max, m_cnt, v;
    int exp_cnt;
    logic [15:0] vec [4];

    initial begin
        vec[0] = 16'd3; vec[1] = 16'd7; vec[2] = 16'd0; vec[3] = 16'd9;
        a_start = 0; a_in_valid = 0; a_in_data = 0; a_res_ready = 0;
        s_start = 0; s_in_valid = 0; s_in_data = 0; s_res_ready = 0;
        d_start = 0; d_in_valid = 0; d_in_data = 0; d_res_ready = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_sum",   32'(a_res_sum), 0);
        chk("rst_min",   32'(a_res_min), 0);
        chk("rst_count", 32'(a_res_count), 0);
        chk("rst_ready", 32'(a_in_ready), 0);
        chk("rst_valid", 32'(a_res_valid), 0);
        chk("rst_busy",  32'(a_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Reset mid-burst on the default instance
        d_start = 1;
        tick();
        d_start = 0;
        chk("mid_busy", 32'(d_busy), 1);
        d_in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            d_in_data = 16'(i + 1);
            tick();
        end
        d_in_valid = 0;
        chk("mid_count5", 32'(d_res_count), 5);
        chk("mid_sum15",  32'(d_res_sum), 15);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sum",   32'(d_res_sum), 0);
        chk("mid_rst_count", 32'(d_res_count), 0);
        chk("mid_rst_max",   32'(d_res_max), 0);
        chk("mid_rst_min",   32'(d_res_min), 0);
        chk("mid_rst_ready", 32'(d_in_ready), 0);
        chk("mid_rst_busy",  32'(d_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mid_idle_ready", 32'(d_in_ready), 0);
        chk("mid_idle_busy",  32'(d_busy), 0);

        // Basic burst 3,7,0,9 back-to-back
        a_start = 1;
        tick();
        a_start = 0;
        chk("open_min",   32'(a_res_min), 32'hFFFF);
        chk("open_max",   32'(a_res_max), 0);
        chk("open_ready", 32'(a_in_ready), 1);
        a_in_valid = 1;
        a_in_data = 16'd3;
        tick();
        chk("lat_sum", 32'(a_res_sum), 3);
        chk("lat_cnt", 32'(a_res_count), 1);
        a_in_data = 16'd7; tick();
        a_in_data = 16'd0; tick();
        chk("basic_valid_early", 32'(a_res_valid), 0);
        a_in_data = 16'd9; tick();
        a_in_valid = 0;
        chk("basic_valid", 32'(a_res_valid), 1);
        chk("basic_sum",   32'(a_res_sum), 19);
        chk("basic_max",   32'(a_res_max), 9);
        chk("basic_min",   32'(a_res_min), 0);
        chk("basic_count", 32'(a_res_count), 4);
        chk("basic_ovf",   32'(a_res_ovf), 0);
        chk("basic_ready", 32'(a_in_ready), 0);

        // Result hold while in_valid and start toggle
        for (int i = 0; i < 10; i++) begin
            a_in_valid = i[0];
            a_start = ~i[0];
            a_in_data = 16'hFFFF;
            tick();
            chk("hold_sum",   32'(a_res_sum), 19);
            chk("hold_max",   32'(a_res_max), 9);
            chk("hold_min",   32'(a_res_min), 0);
            chk("hold_count", 32'(a_res_count), 4);
            chk("hold_valid", 32'(a_res_valid), 1);
            chk("hold_ready", 32'(a_in_ready), 0);
        end
        a_in_valid = 0;
        a_res_ready = 1;
        a_start = 1;
        tick();
        a_res_ready = 0;
        a_start = 0;
        chk("rel_valid", 32'(a_res_valid), 0);
        chk("rel_busy",  32'(a_busy), 0);
        chk("rel_keep",  32'(a_res_sum), 19);
        tick();
        chk("rel_start_dropped", 32'(a_busy), 0);
        chk("rel_idle_ready",    32'(a_in_ready), 0);

        // Gapped burst, same data
        a_start = 1;
        tick();
        a_start = 0;
        for (int k = 0; k < 4; k++) begin
            a_in_valid = 1;
            a_in_data = vec[k];
            tick();
            a_in_valid = 0;
            chk("gap_cnt", 32'(a_res_count), 32'(k + 1));
            if (k < 3) begin
                repeat (2) begin
                    tick();
                    chk("gap_hold_cnt", 32'(a_res_count), 32'(k + 1));
                end
            end
        end
        chk("gap_valid", 32'(a_res_valid), 1);
        chk("gap_sum",   32'(a_res_sum), 19);
        chk("gap_max",   32'(a_res_max), 9);
        chk("gap_min",   32'(a_res_min), 0);
        a_res_ready = 1;
        tick();
        a_res_ready = 0;

        // Saturation with ACC_W=17
        s_start = 1;
        tick();
        s_start = 0;
        s_in_valid = 1;
        s_in_data = 16'hFFFF;
        tick();
        chk("sat1_sum", 32'(s_res_sum), 32'h0FFFF);
        chk("sat1_ovf", 32'(s_res_ovf), 0);
        tick();
        chk("sat2_sum", 32'(s_res_sum), 32'h1FFFE);
        chk("sat2_ovf", 32'(s_res_ovf), 0);
        tick();
        chk("sat3_sum", 32'(s_res_sum), 32'h1FFFF);
        chk("sat3_ovf", 32'(s_res_ovf), 1);
        tick();
        s_in_valid = 0;
        chk("sat4_sum",   32'(s_res_sum), 32'h1FFFF);
        chk("sat4_ovf",   32'(s_res_ovf), 1);
        chk("sat4_max",   32'(s_res_max), 32'hFFFF);
        chk("sat4_min",   32'(s_res_min), 32'hFFFF);
        chk("sat4_valid", 32'(s_res_valid), 1);

        // Default 1000-sample burst against a reference model
        d_start = 1;
        tick();
        d_start = 0;
        m_sum = 0; m_min = 32'hFFFF; m_max = 0; m_cnt = 0;
        for (int c = 0; c < 5000 && m_cnt < 1000; c++) begin
            d_start = (m_cnt == 500) ? 1'b1 : 1'b0;
            if ($urandom_range(3) == 0) begin
                d_in_valid = 0;
            end else begin
                v = $urandom % 10;
                d_in_valid = 1;
                d_in_data = 16'(v);
                m_sum += v;
                if (v < m_min) m_min = v;
                if (v > m_max) m_max = v;
                m_cnt++;
            end
            tick();
            if (d_start) begin
                exp_cnt = int'(m_cnt);
                chk("dflt_start_ignored", 32'(d_res_count), 32'(exp_cnt));
            end
        end
        d_in_valid = 0;
        d_start = 0;
        chk("dflt_model_cnt", m_cnt, 1000);
        chk("dflt_valid", 32'(d_res_valid), 1);
        chk("dflt_count", 32'(d_res_count), 1000);
        chk("dflt_sum",   32'(d_res_sum), m_sum);
        chk("dflt_min",   32'(d_res_min), m_min);
        chk("dflt_max",   32'(d_res_max), m_max);
        chk("dflt_ovf",   32'(d_res_ovf), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
